// File: rtl/req_client_if.sv
// Handshake bundle between one arbiter client and its environment.
// The master side is the requester (req_client); the slave side is whatever
// drives the command/grant inputs and observes the request status.
interface req_client_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             gen;
    logic             req;
    logic             busy;
    logic             beat;
    logic             done;
    logic             timeout;

    modport master (
        input  start,
        input  len,
        input  gen,
        output req,
        output busy,
        output beat,
        output done,
        output timeout
    );

    modport slave (
        output start,
        output len,
        output gen,
        input  req,
        input  busy,
        input  beat,
        input  done,
        input  timeout
    );
endinterface

// File: rtl/req_client.sv
// Upstream requester for a two-client arbiter.
// A single-cycle start with a burst length becomes a level request held until
// grant; granted beats are counted down, then the request is dropped for one
// RELEASE cycle so the arbiter always sees req fall between bursts. If no
// grant arrives within TIMEOUT cycles the request is abandoned.
//
// Handshake: req is a level held from the cycle after start until the last
// beat (or timeout). The arbiter grants with gen; every cycle in XFER with
// gen high transfers exactly one beat (beat=1). gen low in XFER is a stall,
// not a cancel. done/timeout are one-cycle pulses and never coincide.
module req_client #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    req_client_if.master bus,
    output logic [1:0]   o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    // Wait counter is 8 bits wide so the full 1..255 timeout range fits.
    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [7:0]       r_wait_cnt;
    logic             r_done;
    logic             r_timeout;

    logic [1:0]       w_next_state;
    logic [LEN_W-1:0] w_next_remaining;
    logic [7:0]       w_next_wait_cnt;
    logic             w_next_done;
    logic             w_next_timeout;
    logic [7:0]       w_wait_inc;

    // Saturating increment: the counter never wraps past TIMEOUT.
    assign w_wait_inc = (r_wait_cnt >= TO_VAL) ? TO_VAL : (r_wait_cnt + 8'd1);

    // Next-state and counter update; done/timeout flags are computed here so
    // they appear as registered one-cycle pulses.
    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_next_wait_cnt  = r_wait_cnt;
        w_next_done      = 1'b0;
        w_next_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_next_state     = S_WAIT;
                        w_next_remaining = bus.len;
                        w_next_wait_cnt  = 8'd0;
                    end else begin
                        // Zero-length command finishes without ever requesting.
                        w_next_done = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Grant is checked first so it wins over an expiring timeout.
                if (bus.gen) begin
                    w_next_state = S_XFER;
                end else begin
                    w_next_wait_cnt = w_wait_inc;
                    if (w_wait_inc == TO_VAL) begin
                        w_next_state   = S_REL;
                        w_next_timeout = 1'b1;
                    end
                end
            end
            S_XFER: begin
                // gen low here is arbiter preemption: hold count and request.
                if (bus.gen) begin
                    if (r_remaining <= {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        w_next_remaining = '0;
                        w_next_state     = S_REL;
                        w_next_done      = 1'b1;
                    end else begin
                        w_next_remaining = r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_REL: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset; reset aborts any
    // burst silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_wait_cnt  <= 8'd0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            r_wait_cnt  <= w_next_wait_cnt;
            r_done      <= w_next_done;
            r_timeout   <= w_next_timeout;
        end
    end

    assign bus.req     = (r_state == S_WAIT) || (r_state == S_XFER);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.beat    = (r_state == S_XFER) && bus.gen;
    assign bus.done    = r_done;
    assign bus.timeout = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_req_client.sv
// Directed bench for req_client: each cycle drives inputs, pushes the
// expected {req,busy,beat,done,timeout} for that cycle and compares it.
module tb_req_client;

    localparam logic [4:0] E_IDLE  = 5'b00000;
    localparam logic [4:0] E_WAIT  = 5'b11000;
    localparam logic [4:0] E_XBEAT = 5'b11100;
    localparam logic [4:0] E_XHOLD = 5'b11000;
    localparam logic [4:0] E_RDONE = 5'b01010;
    localparam logic [4:0] E_RTO   = 5'b01001;
    localparam logic [4:0] E_DONE0 = 5'b00010;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;
    logic [4:0] exp_q[$];

    req_client_if #(.LEN_W(4)) bus ();

    req_client #(
        .LEN_W  (4),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive inputs just after the edge, queue the expected
    // outputs for this cycle, then compare on the falling edge.
    task automatic cyc(input logic rst, input logic s, input logic [3:0] l,
                       input logic g, input logic [4:0] e, input string tag);
        logic [4:0] obs;
        logic [4:0] want;
        @(posedge clk);
        #1;
        reset     = rst;
        bus.start = s;
        bus.len   = l;
        bus.gen   = g;
        exp_q.push_back(e);
        @(negedge clk);
        obs  = {bus.req, bus.busy, bus.beat, bus.done, bus.timeout};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b (req,busy,beat,done,timeout)", tag, obs, want);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.len   = 4'd0;
        bus.gen   = 1'b0;
        @(posedge clk);
        cyc(1, 0, 0, 0, E_IDLE, "reset");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, E_IDLE, "idle");

        // len=3, gen held high
        cyc(0, 1, 3, 0, E_IDLE, "b3_start");
        cyc(0, 0, 0, 1, E_WAIT, "b3_wait");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, E_XBEAT, "b3_beat");
        cyc(0, 0, 0, 0, E_RDONE, "b3_release");
        cyc(0, 0, 0, 0, E_IDLE, "b3_idle");

        // len=2 with preemption gap; start during XFER must be ignored
        cyc(0, 1, 2, 0, E_IDLE, "b2_start");
        cyc(0, 0, 0, 1, E_WAIT, "b2_wait");
        cyc(0, 0, 0, 1, E_XBEAT, "b2_beat1");
        cyc(0, 1, 7, 0, E_XHOLD, "b2_gap1");
        cyc(0, 0, 0, 0, E_XHOLD, "b2_gap2");
        cyc(0, 0, 0, 1, E_XBEAT, "b2_beat2");
        cyc(0, 0, 0, 0, E_RDONE, "b2_release");
        cyc(0, 0, 0, 0, E_IDLE, "b2_idle1");
        cyc(0, 0, 0, 0, E_IDLE, "b2_idle2");

        // len=5, never granted: 15 wait cycles then timeout
        cyc(0, 1, 5, 0, E_IDLE, "to_start");
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, E_WAIT, "to_wait");
        cyc(0, 0, 0, 0, E_RTO, "to_release");
        cyc(0, 0, 0, 0, E_IDLE, "to_idle");

        // Grant arriving on the last allowed wait cycle wins over timeout
        cyc(0, 1, 1, 0, E_IDLE, "gw_start");
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, E_WAIT, "gw_wait");
        cyc(0, 0, 0, 1, E_WAIT, "gw_grant_last");
        cyc(0, 0, 0, 1, E_XBEAT, "gw_beat");
        cyc(0, 0, 0, 0, E_RDONE, "gw_release");
        cyc(0, 0, 0, 0, E_IDLE, "gw_idle");

        // Zero-length command
        cyc(0, 1, 0, 0, E_IDLE, "z_start");
        cyc(0, 0, 0, 0, E_DONE0, "z_done");
        cyc(0, 0, 0, 0, E_IDLE, "z_idle");

        // len=4, second start ignored, reset after 2nd beat
        cyc(0, 1, 4, 0, E_IDLE, "r_start");
        cyc(0, 0, 0, 1, E_WAIT, "r_wait");
        cyc(0, 0, 0, 1, E_XBEAT, "r_beat1");
        cyc(0, 1, 7, 1, E_XBEAT, "r_beat2_start_ignored");
        cyc(1, 0, 0, 0, E_XHOLD, "r_reset_cycle");
        cyc(0, 0, 0, 0, E_IDLE, "r_after_reset");
        cyc(0, 0, 0, 0, E_IDLE, "r_no_done");
        cyc(0, 1, 1, 0, E_IDLE, "r1_start");
        cyc(0, 0, 0, 1, E_WAIT, "r1_wait");
        cyc(0, 0, 0, 1, E_XBEAT, "r1_beat");
        cyc(0, 0, 0, 0, E_RDONE, "r1_release");
        cyc(0, 0, 0, 0, E_IDLE, "r1_idle");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_client.md
Name: req_client

Overview:
- Upstream requester for the two-client round-robin/priority arbiter FSM; one instance drives each req_N/gen_N pair.
- Converts a single-cycle start command with a burst length into a level request held until grant, counts granted transfer beats, then releases the request.
- Gives up on the request if no grant arrives within a bounded wait.

Parameters:
- LEN_W, 4: width of burst length input; max burst 2^LEN_W-1 beats.
- TIMEOUT, 15: max cycles spent in WAIT_GNT with gen low before abandoning; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle command pulse; honoured only in IDLE
- len  input  LEN_W  burst length, sampled with start
- gen  input  1  grant from arbiter for this client
- req  output  1  request to arbiter
- busy  output  1  high in any state other than IDLE
- beat  output  1  one transfer beat consumed this cycle
- done  output  1  one-cycle pulse: burst completed or zero-length command finished
- timeout  output  1  one-cycle pulse: request abandoned without grant

Behaviour:
- Synchronous active-high reset: state=IDLE, counters=0; req=0, busy=0, beat=0, done=0, timeout=0 in the cycle after the reset edge. Reset mid-burst aborts immediately; no done/timeout generated.
- States: IDLE, WAIT_GNT, XFER, RELEASE. req, busy, done, timeout are registered and decoded from state/flags; beat = (state==XFER) & gen, combinational.
- IDLE: req=0, busy=0. start=1 & len!=0: latch remaining=len, clear wait counter, go WAIT_GNT. start=1 & len==0: stay IDLE, done=1 for the next cycle only. start outside IDLE is ignored (no queueing).
- WAIT_GNT: req=1, busy=1. Each cycle with gen=0, wait counter +1. gen=1 sampled: go XFER. Wait counter reaches TIMEOUT with gen=0: go RELEASE with timeout flag set. Grant and timeout in the same cycle: grant wins.
- XFER: req=1, busy=1. Every cycle with gen=1, beat=1 and remaining decrements by 1. Beat with remaining==1: go RELEASE with done flag set. gen=0 mid-burst (arbiter preemption): beat=0, remaining held, stay in XFER with req high; no timeout applies in XFER.
- RELEASE: exactly one cycle; req=0, busy=1; done=1 if the burst completed, else timeout=1 (mutually exclusive). Next state IDLE. Guarantees the arbiter sees req drop for at least one cycle between bursts.
- Latency: start edge -> req high next cycle; grant seen -> first beat one cycle later; last beat -> req low next cycle.
- Counters never wrap: remaining stops at 0; wait counter saturates at TIMEOUT.

Test Plan:
- Reset 2 cycles, then idle 3 cycles -> req=busy=beat=done=timeout=0 throughout.
- start with len=3; gen held high from the cycle after req rises -> req high 1 cycle after start; beat=1 for exactly 3 consecutive cycles; next cycle RELEASE with req=0, done=1, busy=1; then IDLE with busy=0.
- start with len=2; gen high 1 cycle, low 2 cycles, high 1 cycle -> beats on cycles 1 and 4 of XFER only; req stays high through the gap; done after the 2nd beat.
- start with len=5, TIMEOUT=15, gen never asserted -> req high for 15 cycles, then one RELEASE cycle with req=0, timeout=1, done=0; beat never asserted.
- start with len=0 -> req stays 0; done=1 for exactly one cycle; busy stays 0.
- start with len=4; reset asserted after the 2nd beat; second start issued during XFER -> second start is ignored; reset forces all outputs to 0 the next cycle with no done pulse; a new start with len=1 afterwards completes normally with done=1.
